rope_controller: RTL and testbench

Sequencer for the player's rope (harpoon) in the game datapath. On a fire request it latches the player's X position. It then grows the rope upward by a fixed step each video frame until it reaches the ceiling, holds it there for a fixed number of frames, and retracts it. A ball hit retracts it at once. Its outputs drive the position/head inputs of the rope drawing object and feed the collision and score logic.

---
 rtl/rope_pkg.sv | 10 +
 rtl/rise_detect.sv | 18 +
 rtl/rope_controller.sv | 136 +++++++++++++
 tb/tb_rope_controller.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/rope_pkg.sv
// Screen constants and state type shared by the rope sequencer, drawer and player logic.
package rope_pkg;

  localparam int COORD_W = 11;
  localparam logic [COORD_W-1:0] CEILING_Y = 11'd16;
  localparam logic [COORD_W-1:0] FLOOR_Y   = 11'd440;

  typedef enum logic [1:0] {IDLE, EXTEND, HOLD} rope_state_t;

endpackage

// File: rtl/rise_detect.sv
// Registers a level input and flags its 0->1 transition for one clock.
module rise_detect (
  input  logic clk,
  input  logic resetN,
  input  logic din,
  output logic rise
);

  logic din_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) din_q <= 1'b0;
    else         din_q <= din;
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/rope_controller.sv
// Rope (harpoon) sequencer: launch at the player, rise once per frame, hold at the
// ceiling, retract on timeout or ball hit.
//   state  | meaning
//   IDLE   | no rope; head parked at FLOOR_Y, waiting for an armed fire edge
//   EXTEND | head rising SPEED pixels per frame towards CEILING_Y
//   HOLD   | head at CEILING_Y, counting down HOLD_FRAMES frames
module rope_controller
  import rope_pkg::*;
#(
  parameter logic [COORD_W-1:0] CEILING_Y   = rope_pkg::CEILING_Y,
  parameter logic [COORD_W-1:0] FLOOR_Y     = rope_pkg::FLOOR_Y,
  parameter logic [COORD_W-1:0] SPEED       = 11'd8,
  parameter logic [7:0]         HOLD_FRAMES = 8'd30,
  parameter logic [COORD_W-1:0] X_OFFSET    = 11'd14
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               fireReq,
  input  logic [COORD_W-1:0] playerX,
  input  logic               ballCollision,
  output logic [COORD_W-1:0] topLeftX,
  output logic [COORD_W-1:0] topLeftY,
  output logic [COORD_W-1:0] topY,
  output logic               ropeActive,
  output logic               ropeFired,
  output logic               ropeDone
);

  // One extra bit so CEILING_Y + SPEED cannot wrap in the step test.
  localparam logic [COORD_W:0] STEP_LIMIT = {1'b0, CEILING_Y} + {1'b0, SPEED};

  rope_state_t        state, state_n;
  logic [COORD_W-1:0] top_y_n, top_left_x_n;
  logic [7:0]         hold_cnt, hold_cnt_n;
  logic               armed, armed_n;
  logic               fired_n, done_n, active_n;
  logic               fire_rise;

  rise_detect u_fire_edge (
    .clk    (clk),
    .resetN (resetN),
    .din    (fireReq),
    .rise   (fire_rise)
  );

  assign topLeftY = CEILING_Y;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      topY       <= FLOOR_Y;
      topLeftX   <= '0;
      hold_cnt   <= '0;
      armed      <= 1'b1;
      ropeActive <= 1'b0;
      ropeFired  <= 1'b0;
      ropeDone   <= 1'b0;
    end else begin
      state      <= state_n;
      topY       <= top_y_n;
      topLeftX   <= top_left_x_n;
      hold_cnt   <= hold_cnt_n;
      armed      <= armed_n;
      ropeActive <= active_n;
      ropeFired  <= fired_n;
      ropeDone   <= done_n;
    end
  end

  always_comb begin
    state_n      = state;
    top_y_n      = topY;
    top_left_x_n = topLeftX;
    hold_cnt_n   = hold_cnt;
    armed_n      = armed;
    fired_n      = 1'b0;
    done_n       = 1'b0;
    if (!fireReq) armed_n = 1'b1;

    case (state)
      IDLE: begin
        top_y_n = FLOOR_Y;
        if (fire_rise && armed) begin
          top_left_x_n = playerX + X_OFFSET;
          fired_n      = 1'b1;
          armed_n      = 1'b0;
          state_n      = EXTEND;
        end
      end
      EXTEND: begin
        if (ballCollision) begin
          top_y_n = FLOOR_Y;
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (startOfFrame) begin
          if ({1'b0, topY} >= STEP_LIMIT) begin
            top_y_n = topY - SPEED;
          end else begin
            top_y_n    = CEILING_Y;
            hold_cnt_n = HOLD_FRAMES;
            if (HOLD_FRAMES == 8'd0) begin
              done_n  = 1'b1;
              state_n = IDLE;
            end else begin
              state_n = HOLD;
            end
          end
        end
      end
      HOLD: begin
        top_y_n = CEILING_Y;
        if (ballCollision) begin
          top_y_n = FLOOR_Y;
          done_n  = 1'b1;
          state_n = IDLE;
        end else if (startOfFrame) begin
          if (hold_cnt == 8'd1) begin
            top_y_n = FLOOR_Y;
            done_n  = 1'b1;
            state_n = IDLE;
          end else begin
            hold_cnt_n = hold_cnt - 8'd1;
          end
        end
      end
      default: begin
        top_y_n = FLOOR_Y;
        state_n = IDLE;
      end
    endcase

    active_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_rope_controller.sv
// Bench for rope_controller: three parameterisations driven in lock-step and compared
// every cycle against a frame-level model of the rope, plus hand-computed spot values.
module tb_rope_controller;

  logic        clk;
  logic        resetN;
  logic        startOfFrame;
  logic        fireReq;
  logic [10:0] playerX;
  logic        ballCollision;

  logic [10:0] tlx [3];
  logic [10:0] tly [3];
  logic [10:0] ty  [3];
  logic        act [3];
  logic        fir [3];
  logic        dn  [3];

  int checks = 0;
  int errors = 0;
  bit run_cmp = 0;

  // u0 defaults, u1 one-step climb with no hold, u2 step that does not divide the climb
  rope_controller u0 (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .fireReq(fireReq),
    .playerX(playerX), .ballCollision(ballCollision), .topLeftX(tlx[0]),
    .topLeftY(tly[0]), .topY(ty[0]), .ropeActive(act[0]), .ropeFired(fir[0]),
    .ropeDone(dn[0]));

  rope_controller #(.SPEED(11'd424), .HOLD_FRAMES(8'd0)) u1 (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .fireReq(fireReq),
    .playerX(playerX), .ballCollision(ballCollision), .topLeftX(tlx[1]),
    .topLeftY(tly[1]), .topY(ty[1]), .ropeActive(act[1]), .ropeFired(fir[1]),
    .ropeDone(dn[1]));

  rope_controller #(.SPEED(11'd7)) u2 (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .fireReq(fireReq),
    .playerX(playerX), .ballCollision(ballCollision), .topLeftX(tlx[2]),
    .topLeftY(tly[2]), .topY(ty[2]), .ropeActive(act[2]), .ropeFired(fir[2]),
    .ropeDone(dn[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: phase 0 = no rope, 1 = climbing, 2 = parked at ceiling
  int spd [3] = '{8, 424, 7};
  int hld [3] = '{30, 0, 30};
  int m_phase [3];
  int m_y     [3];
  int m_x     [3];
  int m_left  [3];
  bit m_armed [3];
  bit m_fired [3];
  bit m_done  [3];
  bit m_prev;

  task automatic model_step();
    bit rise;
    if (!resetN) begin
      m_prev = 1'b0;
      for (int i = 0; i < 3; i++) begin
        m_phase[i] = 0; m_y[i] = 440; m_x[i] = 0; m_left[i] = 0;
        m_armed[i] = 1'b1; m_fired[i] = 1'b0; m_done[i] = 1'b0;
      end
    end else begin
      rise   = fireReq && !m_prev;
      m_prev = fireReq;
      for (int i = 0; i < 3; i++) begin
        m_fired[i] = 1'b0;
        m_done[i]  = 1'b0;
        if (m_phase[i] == 0) begin
          m_y[i] = 440;
          if (rise && m_armed[i]) begin
            m_x[i] = (int'(playerX) + 14) % 2048;
            m_fired[i] = 1'b1;
            m_armed[i] = 1'b0;
            m_phase[i] = 1;
          end
        end else if (ballCollision) begin
          m_phase[i] = 0; m_y[i] = 440; m_done[i] = 1'b1;
        end else if (startOfFrame && m_phase[i] == 1) begin
          if (m_y[i] - spd[i] >= 16) m_y[i] = m_y[i] - spd[i];
          else begin
            m_y[i] = 16;
            if (hld[i] == 0) begin m_phase[i] = 0; m_done[i] = 1'b1; end
            else begin m_phase[i] = 2; m_left[i] = hld[i]; end
          end
        end else if (startOfFrame && m_phase[i] == 2) begin
          m_left[i] = m_left[i] - 1;
          if (m_left[i] == 0) begin m_phase[i] = 0; m_y[i] = 440; m_done[i] = 1'b1; end
        end
        if (!fireReq) m_armed[i] = 1'b1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge resetN);
    model_step();
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (run_cmp) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("u%0d.topY", i), int'(ty[i]), m_y[i]);
        chk($sformatf("u%0d.topLeftX", i), int'(tlx[i]), m_x[i]);
        chk($sformatf("u%0d.topLeftY", i), int'(tly[i]), 16);
        chk($sformatf("u%0d.ropeActive", i), int'(act[i]), int'(m_phase[i] != 0));
        chk($sformatf("u%0d.ropeFired", i), int'(fir[i]), int'(m_fired[i]));
        chk($sformatf("u%0d.ropeDone", i), int'(dn[i]), int'(m_done[i]));
      end
    end
  end

  // One idle cycle, then a one-clk frame pulse; returns where its update is visible.
  task automatic frames(input int n);
    repeat (n) begin
      @(negedge clk); startOfFrame = 1'b1;
      @(negedge clk); startOfFrame = 1'b0;
    end
  endtask

  initial begin
    resetN = 1'b0; startOfFrame = 1'b0; fireReq = 1'b0; playerX = '0; ballCollision = 1'b0;
    run_cmp = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset topY", int'(ty[0]), 440);
    chk("reset topLeftX", int'(tlx[0]), 0);
    chk("reset topLeftY", int'(tly[0]), 16);
    chk("reset ropeActive", int'(act[0]), 0);
    resetN = 1'b1;

    // launch at playerX = 100
    @(negedge clk); playerX = 11'd100; fireReq = 1'b1;
    @(negedge clk); fireReq = 1'b0; playerX = 11'd500;
    chk("launch ropeFired", int'(fir[0]), 1);
    chk("launch topLeftX", int'(tlx[0]), 114);
    chk("launch topY", int'(ty[0]), 440);
    chk("launch ropeActive", int'(act[0]), 1);
    @(negedge clk);
    chk("launch fired pulse width", int'(fir[0]), 0);
    chk("flight topLeftX held", int'(tlx[0]), 114);

    frames(1);
    chk("u0 first step", int'(ty[0]), 432);
    chk("u1 full-step topY", int'(ty[1]), 16);
    chk("u1 full-step still active", int'(act[1]), 1);
    frames(1);
    chk("u1 no-hold ropeDone", int'(dn[1]), 1);
    chk("u1 no-hold topY", int'(ty[1]), 16);
    chk("u1 no-hold ropeActive", int'(act[1]), 0);
    @(negedge clk);
    chk("u1 parked topY", int'(ty[1]), 440);
    frames(50);
    chk("u0 frame 52 topY", int'(ty[0]), 24);
    frames(1);
    chk("u0 frame 53 topY", int'(ty[0]), 16);
    frames(1);
    chk("u0 frame 54 topY", int'(ty[0]), 16);
    chk("u0 frame 54 active", int'(act[0]), 1);
    frames(6);
    chk("u2 frame 60 topY", int'(ty[2]), 20);
    frames(1);
    chk("u2 frame 61 ceiling", int'(ty[2]), 16);
    frames(22);
    chk("u0 hold 29 active", int'(act[0]), 1);
    chk("u0 hold 29 no done", int'(dn[0]), 0);
    frames(1);
    chk("u0 hold end ropeDone", int'(dn[0]), 1);
    chk("u0 hold end topY", int'(ty[0]), 440);
    chk("u0 hold end active", int'(act[0]), 0);
    frames(7);
    chk("u2 hold end ropeDone", int'(dn[2]), 1);

    // launch near the right edge (X wraps), then ball hit together with a frame at topY 200
    @(negedge clk); playerX = 11'd2040; fireReq = 1'b1;
    @(negedge clk); fireReq = 1'b0;
    chk("wrap topLeftX", int'(tlx[0]), 6);
    frames(30);
    chk("u0 topY before hit", int'(ty[0]), 200);
    @(negedge clk); startOfFrame = 1'b1; ballCollision = 1'b1;
    @(negedge clk); startOfFrame = 1'b0; ballCollision = 1'b0;
    chk("hit topY", int'(ty[0]), 440);
    chk("hit ropeDone", int'(dn[0]), 1);
    chk("hit ropeActive", int'(act[0]), 0);

    // held key: one launch only, re-fire after a one-clk release
    @(negedge clk); fireReq = 1'b1;
    @(negedge clk);
    chk("held launch fired", int'(fir[0]), 1);
    frames(2);
    @(negedge clk); ballCollision = 1'b1;
    @(negedge clk); ballCollision = 1'b0;
    chk("held retract done", int'(dn[0]), 1);
    repeat (5) @(negedge clk);
    chk("held no relaunch", int'(act[0]), 0);
    fireReq = 1'b0;
    @(negedge clk); fireReq = 1'b1;
    @(negedge clk);
    chk("re-press fired", int'(fir[0]), 1);
    chk("re-press active", int'(act[0]), 1);
    fireReq = 1'b0;

    // asynchronous reset while parked at the ceiling
    frames(54);
    frames(3);
    chk("pre-reset hold topY", int'(ty[0]), 16);
    @(posedge clk); #2 resetN = 1'b0;
    #1;
    chk("async reset topY", int'(ty[0]), 440);
    chk("async reset ropeActive", int'(act[0]), 0);
    chk("async reset ropeDone", int'(dn[0]), 0);
    chk("async reset topLeftX", int'(tlx[0]), 0);
    repeat (2) @(negedge clk);
    resetN = 1'b1;
    @(negedge clk); playerX = 11'd30; fireReq = 1'b1;
    @(negedge clk); fireReq = 1'b0;
    chk("post-reset fired", int'(fir[0]), 1);
    chk("post-reset topLeftX", int'(tlx[0]), 44);
    frames(2);
    chk("post-reset topY", int'(ty[0]), 424);

    @(negedge clk);
    run_cmp = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
